// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes,
// FSM encoding and response flag layout.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_NEG  = 2;

    // Overflow is only meaningful for ADD; mask it otherwise.
    function automatic logic [2:0] pack_flags(
        input logic [2:0] ctrl,
        input logic       neg,
        input logic       ovf,
        input logic       zero
    );
        logic [2:0] f;
        f            = '0;
        f[FLAG_NEG]  = neg;
        f[FLAG_OVF]  = ovf & (ctrl == ALU_ADD);
        f[FLAG_ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin picker: on a tie the port not
// granted last time wins. Output is one-hot or zero.
module alu_rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 16-bit ALU between two requesters: accept,
// hold operands for EXEC_CYCLES, then return the result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [2:0]  req_ctrl0,
    input  logic [2:0]  req_ctrl1,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [2:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_neg,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic [1:0] pick;

    alu_rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign req_ready = (state == IDLE) ? pick : 2'b00;

    // Sequencer: accept, settle the ALU, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            alu_ctrl   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        alu_ctrl   <= pick[1] ? req_ctrl1 : req_ctrl0;
                        alu_a      <= pick[1] ? req_a1 : req_a0;
                        alu_b      <= pick[1] ? req_b1 : req_b0;
                        grant_id   <= pick[1];
                        last_grant <= pick[1];
                        cnt        <= CNT_INIT;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_out;
                        rsp_flags <= pack_flags(alu_ctrl, alu_neg,
                                                alu_ovf, alu_zero);
                        rsp_valid <= grant_id ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with behavioural ALUs
// behind two instances (EXEC_CYCLES = 1 and 4).
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  ctrl0, ctrl1;
    logic [15:0] a0, b0, a1, b1;

    logic [1:0]  v1, rr1, rv1, rs1;
    logic [2:0]  ac1, rf1;
    logic [15:0] aa1, ab1, ao1, rd1;
    logic        z1, o1, n1, bz1, gi1;

    logic [1:0]  v4, rr4, rv4, rs4;
    logic [2:0]  ac4, rf4;
    logic [15:0] aa4, ab4, ao4, rd4;
    logic        z4, o4, n4, bz4, gi4;

    int errs = 0;
    int checks = 0;

    // Reference ALU; ovf is deliberately 1 for non-ADD ops.
    function automatic logic [18:0] alu_model(
        input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] y;
        logic        ov;
        y  = '0;
        ov = 1'b1;
        case (c)
            3'd1: y = a & b;
            3'd2: begin
                y  = a + b;
                ov = (a[15] == b[15]) && (y[15] != a[15]);
            end
            3'd3: y = a - b;
            3'd4: y = a << b[3:0];
            3'd5: y = a >> b[3:0];
            default: y = '0;
        endcase
        return {y[15], ov, (y == 16'd0), y};
    endfunction

    assign {n1, o1, z1, ao1} = alu_model(ac1, aa1, ab1);
    assign {n4, o4, z4, ao4} = alu_model(ac4, aa4, ab4);

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rr1),
        .req_ctrl0(ctrl0), .req_ctrl1(ctrl1),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .alu_ctrl(ac1), .alu_a(aa1), .alu_b(ab1),
        .alu_out(ao1), .alu_zero(z1), .alu_ovf(o1), .alu_neg(n1),
        .rsp_valid(rv1), .rsp_ready(rs1),
        .rsp_data(rd1), .rsp_flags(rf1),
        .busy(bz1), .grant_id(gi1)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v4), .req_ready(rr4),
        .req_ctrl0(ctrl0), .req_ctrl1(ctrl1),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .alu_ctrl(ac4), .alu_a(aa4), .alu_b(ab4),
        .alu_out(ao4), .alu_zero(z4), .alu_ovf(o4), .alu_neg(n4),
        .rsp_valid(rv4), .rsp_ready(rs4),
        .rsp_data(rd4), .rsp_flags(rf4),
        .busy(bz4), .grant_id(gi4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_rr1"}, 32'(rr1), 0);
        chk({t, "_rv1"}, 32'(rv1), 0);
        chk({t, "_ac1"}, 32'(ac1), 0);
        chk({t, "_aa1"}, 32'(aa1), 0);
        chk({t, "_ab1"}, 32'(ab1), 0);
        chk({t, "_rd1"}, 32'(rd1), 0);
        chk({t, "_rf1"}, 32'(rf1), 0);
        chk({t, "_bz1"}, 32'(bz1), 0);
        chk({t, "_gi1"}, 32'(gi1), 0);
        chk({t, "_rr4"}, 32'(rr4), 0);
        chk({t, "_rv4"}, 32'(rv4), 0);
        chk({t, "_ac4"}, 32'(ac4), 0);
        chk({t, "_aa4"}, 32'(aa4), 0);
        chk({t, "_ab4"}, 32'(ab4), 0);
        chk({t, "_rd4"}, 32'(rd4), 0);
        chk({t, "_rf4"}, 32'(rf4), 0);
        chk({t, "_bz4"}, 32'(bz4), 0);
        chk({t, "_gi4"}, 32'(gi4), 0);
    endtask

    typedef struct {
        logic        port;
        logic [2:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] oh;
        int n;
        oh = v.port ? 2'b10 : 2'b01;
        @(negedge clk);
        if (v.port) begin
            ctrl1 = v.ctrl; a1 = v.a; b1 = v.b;
        end else begin
            ctrl0 = v.ctrl; a0 = v.a; b0 = v.b;
        end
        v1 = oh;
        #1 chk($sformatf("v%0d_req_ready", idx), 32'(rr1), 32'(oh));
        @(posedge clk);
        #1 v1 = 2'b00;
        chk($sformatf("v%0d_alu_ctrl", idx), 32'(ac1), 32'(v.ctrl));
        chk($sformatf("v%0d_alu_a", idx), 32'(aa1), 32'(v.a));
        chk($sformatf("v%0d_alu_b", idx), 32'(ab1), 32'(v.b));
        chk($sformatf("v%0d_grant_id", idx), 32'(gi1), 32'(v.port));
        n = 0;
        while (rv1 == 2'b00 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(n), 1);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", idx), 32'(rv1), 32'(oh));
        chk($sformatf("v%0d_data", idx), 32'(rd1), 32'(v.data));
        chk($sformatf("v%0d_flags", idx), 32'(rf1), 32'(v.flags));
        rs1 = oh;
        @(posedge clk);
        #1 rs1 = 2'b00;
        chk($sformatf("v%0d_rsp_done", idx), 32'(rv1), 0);
        chk($sformatf("v%0d_idle", idx), 32'(bz1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int n;

        vecs[0] = '{1'b0, ALU_ADD, 16'd10,   16'd5,   16'd15,   3'b000};
        vecs[1] = '{1'b1, ALU_ADD, 16'h7FFF, 16'd1,   16'h8000, 3'b110};
        vecs[2] = '{1'b1, ALU_SUB, 16'd20,   16'd30,  16'hFFF6, 3'b100};
        vecs[3] = '{1'b0, 3'd6,    16'd15,   16'd3,   16'h0000, 3'b001};
        vecs[4] = '{1'b0, ALU_AND, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100};
        vecs[5] = '{1'b1, ALU_SRL, 16'h8000, 16'd15,  16'h0001, 3'b000};
        vecs[6] = '{1'b0, ALU_SUB, 16'd5,    16'd5,   16'h0000, 3'b001};
        vecs[7] = '{1'b1, ALU_SLL, 16'h0001, 16'd15,  16'h8000, 3'b100};
        vecs[8] = '{1'b0, ALU_ADD, 16'h8000, 16'hFFFF, 16'h7FFF, 3'b010};

        rst_n = 1'b0;
        v1 = '0; rs1 = '0; v4 = '0; rs4 = '0;
        ctrl0 = '0; ctrl1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12 chk_reset("rst0");
        @(negedge clk) rst_n = 1'b1;

        // Round-robin: both ports valid, first tie to port 0.
        ctrl0 = ALU_AND; a0 = 16'hFFFF; b0 = 16'h00FF;
        ctrl1 = ALU_AND; a1 = 16'hFFFF; b1 = 16'h0F00;
        rs1 = 2'b11;
        @(negedge clk) v1 = 2'b11;
        g = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            #1;
            if (rr1 != 2'b00) begin
                chk($sformatf("rr_grant%0d", g), 32'(rr1),
                    (g % 2) != 0 ? 32'h2 : 32'h1);
                g++;
            end
            if (rv1 != 2'b00) begin
                chk("rr_one_rsp", 32'(rv1 == 2'b11), 0);
                chk("rr_data", 32'(rd1),
                    rv1[1] ? 32'h0F00 : 32'h00FF);
            end
            @(negedge clk);
        end
        v1 = 2'b00;
        chk("rr_grant_count", 32'(g), 4);
        n = 0;
        while (bz1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rr_drain", 32'(bz1), 0);
        rs1 = 2'b00;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // EXEC_CYCLES=4, SLL with a held response.
        @(negedge clk);
        ctrl0 = ALU_SLL; a0 = 16'h0F0F; b0 = 16'd4;
        ctrl1 = ALU_ADD; a1 = 16'd1; b1 = 16'd1;
        v4 = 2'b01;
        #1 chk("sll_req_ready", 32'(rr4), 1);
        @(posedge clk);
        #1 v4 = 2'b10;
        n = 0;
        while (rv4 == 2'b00 && n < 20) begin
            chk("sll_ready_exec", 32'(rr4), 0);
            @(posedge clk);
            #1 n++;
        end
        chk("sll_latency", 32'(n), 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("sll_hold%0d_data", c), 32'(rd4), 32'hF0F0);
            chk($sformatf("sll_hold%0d_valid", c), 32'(rv4), 1);
            chk($sformatf("sll_hold%0d_ready", c), 32'(rr4), 0);
        end
        @(negedge clk);
        v4 = 2'b00;
        rs4 = 2'b01;
        @(posedge clk);
        #1 rs4 = 2'b00;
        chk("sll_rsp_done", 32'(rv4), 0);

        // Reset during EXEC after a port-0 grant.
        @(negedge clk);
        ctrl0 = ALU_ADD; a0 = 16'd100; b0 = 16'd200;
        v4 = 2'b01;
        @(posedge clk);
        #1 v4 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(bz4), 1);
        rst_n = 1'b0;
        #1 chk_reset("rst1");
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rv", c), 32'(rv4), 0);
        end
        ctrl0 = ALU_ADD; a0 = 16'd7; b0 = 16'd8;
        ctrl1 = ALU_SUB; a1 = 16'd9; b1 = 16'd1;
        v4 = 2'b11;
        #1 chk("tie_after_rst", 32'(rr4), 1);
        @(posedge clk);
        #1 v4 = 2'b00;
        n = 0;
        while (rv4 == 2'b00 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("tie_latency", 32'(n), 4);
        chk("tie_rsp_valid", 32'(rv4), 1);
        chk("tie_data", 32'(rd4), 15);
        chk("tie_flags", 32'(rf4), 0);
        @(negedge clk) rs4 = 2'b01;
        @(posedge clk);
        #1 rs4 = 2'b00;
        chk("tie_idle", 32'(bz4), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares the single 16-bit ALU between two requesters (port 0: execute stage, port 1: address/branch-compare unit). It accepts one operation at a time through a valid/ready handshake, arbitrates round-robin, holds the ALU operands stable for a programmable number of settle cycles, and registers the result and flags. The result returns on the winning requester's response port, which also uses valid/ready. It sits between the requesters and the ALU instance, and it alone drives `alu_ctrl`, `a` and `b`.

## Interface
- `EXEC_CYCLES`, default 1: ALU settle cycles before the result is sampled. Legal range is 1..15.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid[1:0]` input 2: per-port request valid.
- `req_ready[1:0]` output 2: per-port request accepted this cycle.
- `req_ctrl0`, `req_ctrl1` input 3 each: opcode. 1 is AND, 2 is ADD, 3 is SUB, 4 is SLL, 5 is SRL. Any other code gives a result of 0.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 16 each: signed operands.
- `alu_ctrl` output 3: registered opcode to the ALU.
- `alu_a`, `alu_b` output 16: registered operands to the ALU.
- `alu_out` input 16: ALU result.
- `alu_zero`, `alu_ovf`, `alu_neg` input 1 each: ALU flags.
- `rsp_valid[1:0]` output 2: per-port response valid.
- `rsp_ready[1:0]` input 2: per-port response consumed.
- `rsp_data` output 16: registered result, shared by both ports.
- `rsp_flags` output 3: registered flags {neg, ovf, zero}, shared by both ports.
- `busy` output 1: high when the state is not IDLE.
- `grant_id` output 1: port owning the current or last operation.

## Operation
- There are three FSM states: IDLE, EXEC and RESP. The reset state is IDLE.
- **IDLE:**
  - If exactly one `req_valid` bit is set, that port wins.
  - If both are set, the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie.
  - `req_ready[i]` is high combinationally only in IDLE, and only for the winner.
  - On handshake, capture the opcode and operands into `alu_ctrl`/`alu_a`/`alu_b`, set `grant_id`, update `last_grant`, load `cnt` = `EXEC_CYCLES`−1, and go to EXEC.
- **EXEC:**
  - ALU inputs are held constant.
  - When `cnt`==0, register `alu_out` into `rsp_data`, register the flags into `rsp_flags`, and go to RESP. Otherwise decrement `cnt`.
- **RESP:**
  - `rsp_valid[grant_id]` is high. The other bit is 0.
  - `rsp_data` and `rsp_flags` are held until `rsp_ready[grant_id]`. The cycle after that handshake, the state is IDLE.
  - `rsp_ready` on the non-owning port is ignored.
- **Flag rules:**
  - The ovf flag is registered as `alu_ovf` only when the opcode is 2. It is forced to 0 for all other opcodes, because the ALU's overflow output is only defined for ADD.
  - zero and neg pass through unmodified.
  - Invalid opcodes are accepted and complete normally with data 0 and flags 3'b001.
- No new request is accepted while `busy` is high. A requester may hold `req_valid` with changing payload, and only the payload at the handshake edge is used.
- **Reset values (any time):** state IDLE, `req_ready` 0, `rsp_valid` 0, `alu_ctrl` 0, `alu_a` 0, `alu_b` 0, `rsp_data` 0, `rsp_flags` 0, `busy` 0, `grant_id` 0, `last_grant` 1.
- An in-flight operation is discarded on reset, with no response.

## Timing
- Handshake at edge k. EXEC occupies edges k+1 .. k+`EXEC_CYCLES`.
- `rsp_valid` is high after edge k+`EXEC_CYCLES`.
- The request-to-response latency is `EXEC_CYCLES` cycles.
- Minimum op spacing is `EXEC_CYCLES`+2 cycles, covering EXEC, one RESP cycle and one IDLE cycle.
- `req_ready` depends combinationally on `req_valid` and the state only. It never depends on `rsp_ready`.
- All other outputs are registered.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `ALU_AND`=1, `ALU_ADD`=2, `ALU_SUB`=3, `ALU_SLL`=4, `ALU_SRL`=5;
  - the state encoding IDLE/EXEC/RESP;
  - the flag bit positions.
- One sub-module, `alu_rr_arb2`: the 2-way round-robin picker. It takes `req_valid` and `last_grant` and produces a one-hot grant.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Port 0 ADD a=10, b=5, `EXEC_CYCLES`=1 → `req_ready[0]` is high the same cycle. `rsp_valid[0]` is high one cycle later, with `rsp_data`=15 and `rsp_flags`=3'b000.
- Port 1 ADD 32767+1 → `rsp_data`=−32768 and `rsp_flags`=3'b110. Then SUB 20−30 → `rsp_data`=−10 and `rsp_flags`=3'b100, with ovf masked to 0.
- Both ports valid continuously with AND ops → grants alternate 0,1,0,1. `rsp_valid` is never high on both ports.
- `EXEC_CYCLES`=4, SLL 16'h0F0F by 4, `rsp_ready` held low for 3 cycles → `rsp_data`=16'hF0F0 is stable for the whole hold. `req_ready` stays 0 throughout.
- Opcode 6 with a=15, b=3 → `rsp_data`=0 and `rsp_flags`=3'b001.
- Assert `rst_n` low mid-EXEC → all outputs go to reset values immediately, with no response. After release, the first tie grants port 0.
